fifo_rr_scheduler: RTL
======================

# fifo_rr_scheduler

Round-robin read scheduler that drains N_PORTS first-word-fall-through FIFOs onto one shared valid/ready output stream. It sits between a bank of per-source FWFT FIFOs and a single downstream consumer. It grants one FIFO at a time, caps each grant at MAX_BURST words, and drives that FIFO's read enable directly.

## Interface
- N_PORTS, 4, number of FIFOs served (≥2)
- DATA_WIDTH, 32, word width, equal to the FIFO data width
- MAX_BURST, 4, max words transferred per grant (≥1)
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  N_PORTS  per-port enable mask, sampled only at arbitration
- fifo_empty_i  in  N_PORTS  empty flag of each FIFO
- fifo_data_i  in  N_PORTS×DATA_WIDTH  FWFT head word of each FIFO, port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- fifo_rd_en_o  out  N_PORTS  read enable to each FIFO, one-hot or zero
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  downstream accepts word
- m_data_o  out  DATA_WIDTH  output word
- m_port_o  out  $clog2(N_PORTS)  index of the port that sourced m_data_o
- busy_o  out  1  high while a grant is held (state SERVE)

## Operation
- Two-state FSM.
- IDLE:
  - req[k] = en_i[k] & ~fifo_empty_i[k].
  - If any req is set, select the first requester in the order last_q+1, last_q+2, …, last_q, modulo N_PORTS.
  - Register it into grant_q and last_q, clear beat_q, and go to SERVE.
  - Otherwise stay in IDLE.
- SERVE:
  - m_valid_o = ~fifo_empty_i[grant_q].
  - m_data_o = fifo_data_i[grant_q].
  - m_port_o = grant_q.
  - fifo_rd_en_o[grant_q] = m_valid_o & m_ready_i (a transfer). All other bits are 0.
  - On a transfer, beat_q increments.
  - Go to IDLE if a transfer occurs with beat_q == MAX_BURST-1, or if fifo_empty_i[grant_q] is high (the FIFO drained).
  - Otherwise hold the grant.
- en_i changes during SERVE are ignored. The grant is never revoked while m_valid_o is high. m_data_o therefore stays stable until accepted (standard valid/ready rule).
- beat_q width is $clog2(MAX_BURST+1). beat_q never exceeds MAX_BURST-1. It resets to 0 on each new grant.
- In IDLE, m_valid_o = 0 and fifo_rd_en_o = 0. m_data_o and m_port_o continue to reflect grant_q (don't-care for consumers).
- Reset values:
  - state = IDLE, grant_q = 0, last_q = N_PORTS-1, so port 0 has first priority.
  - beat_q = 0, m_valid_o = 0, fifo_rd_en_o = 0, busy_o = 0, m_port_o = 0.
- fifo_rd_en_o and m_valid_o are forced to 0 combinationally whenever rst_i is high.

## Timing
- Arbitration latency: a FIFO that goes non-empty while the FSM is IDLE gets m_valid_o on the next cycle after it is seen non-empty.
- Each grant has a 1-cycle IDLE bubble after release. Maximum throughput is MAX_BURST words per MAX_BURST+1 cycles when all FIFOs are full and m_ready_i is high.
- A FIFO drained before MAX_BURST words costs one extra cycle: the SERVE cycle in which empty is observed transfers nothing, then the FSM moves to IDLE.
- Simultaneous requests are resolved strictly by rotation from last_q. A port that is granted is lowest priority at the next arbitration.
- m_ready_i low stalls indefinitely with no timeout. beat_q and the grant hold.
- If rst_i is asserted mid-burst, the FSM returns to IDLE at the next edge and no read is issued in the reset cycle. The FIFO contents are untouched by the scheduler.
- With MAX_BURST = 1, every transfer releases the grant, giving strict per-word round-robin.

## Test plan
- Reset, then port 2 alone receives 3 words (A, B, C), with m_ready_i=1 and all en_i set → after 1 IDLE cycle: m_port_o=2, output A, B, C on consecutive cycles, fifo_rd_en_o=4'b0100 on each. The FIFO then empties → SERVE then IDLE.
- All 4 FIFOs hold 8 words, MAX_BURST=4, ready=1 → grant order 0,1,2,3,0,…; each grant transfers exactly 4 words, with 1 bubble between grants.
- Port 1 holds words D0, D1 and m_ready_i toggles 0,1,0,1 → m_valid_o stays high and m_data_o holds D0 through the stall. rd_en pulses only on ready-high cycles.
- en_i=4'b1011 with all FIFOs non-empty → port 2 is never granted. Clearing en_i[0] mid-grant to port 0 does not cut the burst.
- Assert rst_i for 1 cycle during the 2nd beat of a port-3 burst → no rd_en in the reset cycle. The next grant goes to the first non-empty port starting from port 0.
- Fuzz check on every cycle: popcount(fifo_rd_en_o) ≤ 1, no rd_en to an empty FIFO, and per-port output order matches that port's FIFO write order.

Source files
------------

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin burst-capped drain of N FWFT FIFOs onto one valid/ready stream
module fifo_rr_scheduler #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_PORTS-1:0]              en_i,
    input  logic [N_PORTS-1:0]              fifo_empty_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   fifo_data_i,
    output logic [N_PORTS-1:0]              fifo_rd_en_o,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [DATA_WIDTH-1:0]           m_data_o,
    output logic [$clog2(N_PORTS)-1:0]      m_port_o,
    output logic                            busy_o
);
    localparam int PW = $clog2(N_PORTS);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;
    logic [0:0]            state_q;
    logic [PW-1:0]         grant_q, last_q, pick, cand;
    logic [BW-1:0]         beat_q;
    logic [N_PORTS-1:0]    req;
    logic [DATA_WIDTH-1:0] words [N_PORTS];
    logic                  found, xfer, release_grant;
    for (genvar k = 0; k < N_PORTS; k++) begin : g_words
        assign words[k] = fifo_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
    assign req = en_i & ~fifo_empty_i;
    always_comb begin
        pick  = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = PW'((int'(last_q) + i) % N_PORTS);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end
    assign busy_o        = state_q == SERVE;
    assign m_valid_o     = !rst_i && busy_o && !fifo_empty_i[grant_q];
    assign xfer          = m_valid_o && m_ready_i;
    assign fifo_rd_en_o  = xfer ? N_PORTS'(1) << grant_q : '0;
    assign m_data_o      = words[grant_q];
    assign m_port_o      = grant_q;
    assign release_grant = (xfer && beat_q == BW'(MAX_BURST - 1)) || fifo_empty_i[grant_q];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PW'(N_PORTS - 1);
            beat_q  <= '0;
        end else if (state_q == IDLE) begin
            if (found) begin
                state_q <= SERVE;
                grant_q <= pick;
                last_q  <= pick;
                beat_q  <= '0;
            end
        end else if (release_grant) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else if (xfer) begin
            beat_q  <= beat_q + BW'(1);
        end
    end
endmodule
